// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//   In-order queue of in-flight predicted branches between ID and EX. ID pushes
//   the gshare read index, predicted direction and target; EX pops the oldest
//   entry when the branch resolves. The popped entry drives the gshare PHT/GHR
//   update port one cycle later, together with a one-cycle mispredict pulse and
//   the correct redirect PC for IF.
//
// Optional feature macro: BRQ_STATS_EN
//   defined   -> stat_total / stat_miss saturating counters (cleared by reset only)
//   undefined -> stat_total / stat_miss tied to zero
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   flush                 discard all entries (exception / eret)
//   push, push_*          ID side: new predicted branch (pc, index, take, target)
//   full, empty, count    registered occupancy state
//   resolve, res_*        EX side: oldest branch resolved, actual direction/target
//   upd_wen/windex/take   gshare update port (registered, one-cycle pulse)
//   mispredict            registered one-cycle redirect pulse
//   redirect_pc           correct fetch PC, valid with mispredict
//   stat_total, stat_miss resolved / mispredicted branch counters
// -----------------------------------------------------------------------------
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 8,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [31:0]      push_pc,
  input  logic [IDX_W-1:0] push_index,
  input  logic             push_take,
  input  logic [31:0]      push_target,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  input  logic             resolve,
  input  logic             res_take,
  input  logic [31:0]      res_target,
  output logic             upd_wen,
  output logic [IDX_W-1:0] upd_windex,
  output logic             upd_take,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      stat_total,
  output logic [31:0]      stat_miss
);

  typedef logic [PTR_W:0]   cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    logic [31:0]      pc;
    logic [IDX_W-1:0] idx;
    logic             take;
    logic [31:0]      tgt;
  } ent_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  ptr_t             head_q, head_d, tail_q, tail_d;
  cnt_t             count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             upd_wen_q, upd_wen_d, upd_take_q, upd_take_d;
  logic [IDX_W-1:0] upd_windex_q, upd_windex_d;
  logic             mispredict_q, mispredict_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;

  ent_t             head_ent_s;
  logic             res_ok_s, miss_s, clear_s, push_ok_s;

  // Resolve qualification, miss detection and push acceptance.
  always_comb begin
    head_ent_s = ent_q[head_q];
    res_ok_s   = resolve && !empty_q;
    miss_s     = res_ok_s && ((res_take != head_ent_s.take) ||
                              (res_take && (res_target != head_ent_s.tgt)));
    // A miss makes every younger entry wrong-path, so it clears like a flush.
    clear_s    = flush || miss_s;
    // A full queue can still accept when the head leaves in the same cycle.
    push_ok_s  = push && (!full_q || res_ok_s) && !clear_s;
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push_ok_s) begin
      ent_d[tail_q] = '{pc: push_pc, idx: push_index, take: push_take, tgt: push_target};
      tail_d        = tail_q + ptr_t'(1);
    end else begin
      tail_d = tail_q;
    end
    if (clear_s) begin
      head_d  = tail_q;
      count_d = cnt_t'(0);
    end else begin
      if (res_ok_s) begin
        head_d = head_q + ptr_t'(1);
      end else begin
        head_d = head_q;
      end
      case ({push_ok_s, res_ok_s})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == cnt_t'(0));
  end

  // Next-state for the registered gshare update port and redirect.
  always_comb begin
    upd_wen_d     = res_ok_s;
    mispredict_d  = miss_s && !flush;
    upd_windex_d  = upd_windex_q;
    upd_take_d    = upd_take_q;
    redirect_pc_d = redirect_pc_q;
    if (res_ok_s) begin
      upd_windex_d  = head_ent_s.idx;
      upd_take_d    = res_take;
      // Not-taken falls through past the delay slot.
      redirect_pc_d = res_take ? res_target : (head_ent_s.pc + 32'd8);
    end else begin
      upd_windex_d  = upd_windex_q;
      upd_take_d    = upd_take_q;
      redirect_pc_d = redirect_pc_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q        <= ptr_t'(0);
      tail_q        <= ptr_t'(0);
      count_q       <= cnt_t'(0);
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      upd_wen_q     <= 1'b0;
      upd_windex_q  <= {IDX_W{1'b0}};
      upd_take_q    <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= 32'd0;
    end else begin
      ent_q         <= ent_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      upd_wen_q     <= upd_wen_d;
      upd_windex_q  <= upd_windex_d;
      upd_take_q    <= upd_take_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign full        = full_q;
  assign empty       = empty_q;
  assign count       = count_q;
  assign upd_wen     = upd_wen_q;
  assign upd_windex  = upd_windex_q;
  assign upd_take    = upd_take_q;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;

`ifdef BRQ_STATS_EN
  logic [31:0] stat_total_q, stat_total_d, stat_miss_q, stat_miss_d;

  // Saturating statistics; the miss count includes misses masked by flush.
  always_comb begin
    stat_total_d = stat_total_q;
    stat_miss_d  = stat_miss_q;
    if (res_ok_s && (stat_total_q != 32'hFFFF_FFFF)) begin
      stat_total_d = stat_total_q + 32'd1;
    end else begin
      stat_total_d = stat_total_q;
    end
    if (miss_s && (stat_miss_q != 32'hFFFF_FFFF)) begin
      stat_miss_d = stat_miss_q + 32'd1;
    end else begin
      stat_miss_d = stat_miss_q;
    end
  end

  // Statistics registers, cleared by reset only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_total_q <= 32'd0;
      stat_miss_q  <= 32'd0;
    end else begin
      stat_total_q <= stat_total_d;
      stat_miss_q  <= stat_miss_d;
    end
  end

  assign stat_total = stat_total_q;
  assign stat_miss  = stat_miss_q;
`else
  assign stat_total = 32'd0;
  assign stat_miss  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
  localparam int IDX_W = 8;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0, push = 1'b0, push_take = 1'b0;
  logic             resolve = 1'b0, res_take = 1'b0;
  logic [31:0]      push_pc = 32'd0, push_target = 32'd0, res_target = 32'd0;
  logic [IDX_W-1:0] push_index = '0;
  logic             full, empty, upd_wen, upd_take, mispredict;
  logic [PTR_W:0]   count;
  logic [IDX_W-1:0] upd_windex;
  logic [31:0]      redirect_pc, stat_total, stat_miss;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .push(push), .push_pc(push_pc), .push_index(push_index),
    .push_take(push_take), .push_target(push_target),
    .full(full), .empty(empty), .count(count),
    .resolve(resolve), .res_take(res_take), .res_target(res_target),
    .upd_wen(upd_wen), .upd_windex(upd_windex), .upd_take(upd_take),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_total(stat_total), .stat_miss(stat_miss)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0]      pc;
    logic [IDX_W-1:0] idx;
    logic             take;
    logic [31:0]      tgt;
  } ent_t;

  ent_t             mq[$];
  logic             m_wen, m_take, m_misp;
  logic [IDX_W-1:0] m_idx;
  logic [31:0]      m_rpc, m_tot, m_miss;
  int               n_cmp = 0;
  int               n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_wen = 1'b0; m_take = 1'b0; m_misp = 1'b0; m_idx = '0;
    m_rpc = 32'd0; m_tot = 32'd0; m_miss = 32'd0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    ent_t e;
    bit   room, rok, miss;
    room = (mq.size() < DEPTH);
    rok  = resolve && (mq.size() > 0);
    miss = 1'b0;
    if (rok) begin
      e      = mq.pop_front();
      miss   = (res_take != e.take) || (res_take && (res_target != e.tgt));
      m_wen  = 1'b1;
      m_idx  = e.idx;
      m_take = res_take;
      m_misp = miss && !flush;
      m_rpc  = res_take ? res_target : (e.pc + 32'd8);
      if (m_tot != 32'hFFFF_FFFF) m_tot++;
      if (miss && (m_miss != 32'hFFFF_FFFF)) m_miss++;
    end else begin
      m_wen  = 1'b0;
      m_misp = 1'b0;
    end
    if (flush || miss) mq.delete();
    else if (push && (room || rok))
      mq.push_back('{pc: push_pc, idx: push_index, take: push_take, tgt: push_target});
  endtask

  task automatic compare_all();
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("upd_wen", 32'(upd_wen), 32'(m_wen));
    chk("mispredict", 32'(mispredict), 32'(m_misp));
    if (m_wen) begin
      chk("upd_windex", 32'(upd_windex), 32'(m_idx));
      chk("upd_take", 32'(upd_take), 32'(m_take));
    end
    if (m_misp) chk("redirect_pc", redirect_pc, m_rpc);
`ifdef BRQ_STATS_EN
    chk("stat_total", stat_total, m_tot);
    chk("stat_miss", stat_miss, m_miss);
`else
    chk("stat_total", stat_total, 32'd0);
    chk("stat_miss", stat_miss, 32'd0);
`endif
  endtask

  // One clock: apply inputs, step model, check after the edge.
  task automatic cyc(input logic p, input logic [31:0] pc, input logic [IDX_W-1:0] idx,
                     input logic tk, input logic [31:0] tgt,
                     input logic r, input logic rtk, input logic [31:0] rtgt, input logic f);
    push = p; push_pc = pc; push_index = idx; push_take = tk; push_target = tgt;
    resolve = r; res_take = rtk; res_target = rtgt; flush = f;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    cyc(1'b0, 32'd0, '0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic reset_and_check();
    reset = 1'b1;
    push = 1'b0; resolve = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_upd_wen", 32'(upd_wen), 32'd0);
    chk("rst_upd_windex", 32'(upd_windex), 32'd0);
    chk("rst_upd_take", 32'(upd_take), 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_stat_total", stat_total, 32'd0);
    chk("rst_stat_miss", stat_miss, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] pc_i, tgt_i;
    logic        tk_i;
    model_reset();
    reset_and_check();

    // 1: fill to full, extra push dropped.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'h1000 + 32'(i) * 32'd16, IDX_W'(i), i[0], 32'h2000 + 32'(i) * 32'd16,
          1'b0, 1'b0, 32'd0, 1'b0);
    chk("t1_count4", 32'(count), 32'd4);
    chk("t1_full", 32'(full), 32'd1);
    cyc(1'b1, 32'h5000, 8'hAA, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("t1_drop_count", 32'(count), 32'd4);

    // 5: push+resolve on full queue across wrap, then drain in push order.
    for (int i = 0; i < 4; i++) begin
      tk_i  = i[0];
      tgt_i = 32'h2000 + 32'(i) * 32'd16;
      cyc(1'b1, 32'h1000 + 32'(i + 4) * 32'd16, IDX_W'(i + 4), ~i[0],
          32'h2000 + 32'(i + 4) * 32'd16, 1'b1, tk_i, tgt_i, 1'b0);
      chk("t5_windex", 32'(upd_windex), 32'(i));
      chk("t5_count", 32'(count), 32'd4);
    end
    for (int i = 4; i < 8; i++) begin
      tk_i  = ~i[0];
      tgt_i = 32'h2000 + 32'(i) * 32'd16;
      cyc(1'b0, 32'd0, '0, 1'b0, 32'd0, 1'b1, tk_i, tgt_i, 1'b0);
      chk("t5_drain_windex", 32'(upd_windex), 32'(i));
      chk("t5_drain_misp", 32'(mispredict), 32'd0);
    end
    chk("t5_empty", 32'(empty), 32'd1);

    // 2: correct taken prediction.
    cyc(1'b1, 32'h100, 8'h3C, 1'b1, 32'h200, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 32'd0, '0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h200, 1'b0);
    chk("t2_wen", 32'(upd_wen), 32'd1);
    chk("t2_windex", 32'(upd_windex), 32'h3C);
    chk("t2_take", 32'(upd_take), 32'd1);
    chk("t2_misp", 32'(mispredict), 32'd0);
    chk("t2_empty", 32'(empty), 32'd1);

    // 3: predicted not-taken, actually taken; same-cycle push dropped.
    cyc(1'b1, 32'h100, 8'h11, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 32'h110, 8'h12, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 32'h120, 8'h13, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 32'h130, 8'h14, 1'b0, 32'd0, 1'b1, 1'b1, 32'h180, 1'b0);
    chk("t3_misp", 32'(mispredict), 32'd1);
    chk("t3_rpc", redirect_pc, 32'h180);
    chk("t3_count", 32'(count), 32'd0);
    idle();
    chk("t3_pulse_one", 32'(mispredict), 32'd0);

    // 4: predicted taken, actually not taken -> pc+8.
    cyc(1'b1, 32'h100, 8'h21, 1'b1, 32'h200, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 32'd0, '0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("t4_misp", 32'(mispredict), 32'd1);
    chk("t4_rpc", redirect_pc, 32'h108);

    // 6: flush with concurrent mispredicting resolve, then resolve on empty.
    reset_and_check();
    cyc(1'b1, 32'h300, 8'h31, 1'b1, 32'h400, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 32'h310, 8'h32, 1'b1, 32'h410, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 32'h320, 8'h33, 1'b1, 32'h420, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("t6_wen", 32'(upd_wen), 32'd1);
    chk("t6_windex", 32'(upd_windex), 32'h31);
    chk("t6_misp", 32'(mispredict), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
`ifdef BRQ_STATS_EN
    chk("t6_stat_total", stat_total, 32'd1);
    chk("t6_stat_miss", stat_miss, 32'd1);
`endif
    cyc(1'b0, 32'd0, '0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h500, 1'b0);
    chk("t6_empty_wen", 32'(upd_wen), 32'd0);
    chk("t6_empty_misp", 32'(mispredict), 32'd0);

    // Randomized traffic, with a reset in the middle.
    for (int n = 0; n < 3000; n++) begin
      logic        rp, rr, rf, rtk;
      logic [31:0] rtgt;
      if (n == 1500) reset_and_check();
      rp    = ($urandom_range(0, 9) < 6);
      rr    = ($urandom_range(0, 9) < 5);
      rf    = ($urandom_range(0, 39) == 0);
      pc_i  = {$urandom_range(0, 255), 2'b00};
      tk_i  = $urandom_range(0, 1);
      tgt_i = 32'h2000 + {$urandom_range(0, 3), 4'h0};
      if ((mq.size() > 0) && ($urandom_range(0, 3) != 0)) begin
        rtk  = mq[0].take;
        rtgt = mq[0].tgt;
      end else begin
        rtk  = $urandom_range(0, 1);
        rtgt = 32'h2000 + {$urandom_range(0, 3), 4'h0};
      end
      cyc(rp, pc_i, IDX_W'($urandom), tk_i, tgt_i, rr, rtk, rtgt, rf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
